// File: rtl/shift_pkg.sv
// shift_pkg -- shared definitions for the shift scheduler.
//   state_e  : scheduler FSM states (IDLE / SHIFT / DONE)
//   DW       : operand width (only 8 is supported)
//   AMT_W    : request shift-amount width (amounts 0..31)
//   MAX_STEP : largest shift applied by one pass through the shifter
package shift_pkg;

  localparam int DW       = 8;
  localparam int AMT_W    = 5;
  localparam int MAX_STEP = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_shift8.sv
// barrel_shift8 -- purely combinational 8-bit shifter, 0..7 positions per use.
//   din   : operand
//   shamt : shift distance (0..7)
//   lr    : 1 = shift left, 0 = shift right
//   al    : 1 = arithmetic right shift (sign fill), 0 = logical (zero fill);
//           ignored for left shifts
//   dout  : shifted operand
module barrel_shift8 (
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  input  logic       lr,
  input  logic       al,
  output logic [7:0] dout
);

  // Select direction and fill mode.
  always_comb begin
    dout = 8'h00;
    if (lr) begin
      dout = din << shamt;
    end else if (al) begin
      dout = $unsigned($signed(din) >>> shamt);
    end else begin
      dout = din >> shamt;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// shift_sched -- two-requester shift scheduler sharing one 8-bit barrel shifter.
// A round-robin arbiter accepts one command at a time in IDLE; large shift
// amounts are applied over several SHIFT cycles of at most MAX_STEP positions,
// then the result is held in DONE until the consumer takes it.
//   clk, rst                : clock, synchronous active-high reset
//   reqN_valid / reqN_ready : command handshake for requester N (N = 0, 1)
//   reqN_data/amt/lr/al     : operand, total shift, direction, fill mode
//   resp_valid / resp_ready : result handshake
//   resp_data / resp_id     : shifted result and the issuing requester
//   busy                    : high whenever the FSM is not in IDLE
module shift_sched #(
  parameter int DW       = shift_pkg::DW,
  parameter int AMT_W    = shift_pkg::AMT_W,
  parameter int MAX_STEP = shift_pkg::MAX_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_lr,
  input  logic             req0_al,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_lr,
  input  logic             req1_al,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [DW-1:0]    resp_data,
  output logic             resp_id,
  output logic             busy
);

  import shift_pkg::*;

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             lr_q, lr_d;
  logic             al_q, al_d;
  logic             id_q, id_d;
  // Requester granted most recently; reset to 1 so req0 wins the first tie.
  logic             last_q, last_d;

  logic             grant0_s, grant1_s;
  logic [AMT_W-1:0] step_s;
  logic [DW-1:0]    shift_out_s;

  // Round-robin arbitration between the two requesters.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_q;
      grant1_s = ~last_q;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Per-pass step: min(remaining, MAX_STEP).
  always_comb begin
    step_s = rem_q;
    if (rem_q > MAX_STEP_A) begin
      step_s = MAX_STEP_A;
    end else begin
      step_s = rem_q;
    end
  end

  barrel_shift8 u_shifter (
    .din   (data_q),
    .shamt (step_s[2:0]),
    .lr    (lr_q),
    .al    (al_q),
    .dout  (shift_out_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      rem_q   <= '0;
      lr_q    <= 1'b0;
      al_q    <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      lr_q    <= lr_d;
      al_q    <= al_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    lr_d    = lr_q;
    al_d    = al_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // Readies are only raised in IDLE, so a grant here is an accept.
        if (grant0_s || grant1_s) begin
          id_d   = grant1_s;
          last_d = grant1_s;
          if (grant1_s) begin
            data_d = req1_data;
            rem_d  = req1_amt;
            lr_d   = req1_lr;
            al_d   = req1_al;
          end else begin
            data_d = req0_data;
            rem_d  = req0_amt;
            lr_d   = req0_lr;
            al_d   = req0_al;
          end
          if (rem_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Repeated passes saturate naturally once the total reaches 8.
        data_d = shift_out_s;
        rem_d  = rem_q - step_s;
        if (rem_d == '0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs, decoded from registered state.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      req0_ready = grant0_s;
      req1_ready = grant1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    resp_valid = (state_q == DONE);
    busy       = (state_q != IDLE);
    resp_data  = data_q;
    resp_id    = id_q;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width; only 8 is supported.
REQ-002 The block SHALL have parameter AMT_W, default 5, meaning request shift-amount width (0..31).
REQ-003 The block SHALL have parameter MAX_STEP, default 7, meaning the largest shift applied per pass.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 reqN_valid  input  1  (N=0,1) requester N has a command.
REQ-007 reqN_ready  output  1  (N=0,1) command accepted this cycle when valid&ready.
REQ-008 reqN_data  input  DW  (N=0,1) operand.
REQ-009 reqN_amt  input  AMT_W  (N=0,1) total shift amount.
REQ-010 reqN_lr  input  1  (N=0,1) 1 = shift left, 0 = shift right.
REQ-011 reqN_al  input  1  (N=0,1) 1 = arithmetic (sign fill on right shift), 0 = logical (zero fill); ignored for left shifts.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts result.
REQ-014 resp_data  output  DW  shifted result.
REQ-015 resp_id  output  1  index of the requester that issued the command.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 In IDLE, reqN_ready SHALL be high only for the arbitration winner; both readies SHALL be low in SHIFT and DONE.
REQ-019 Arbitration SHALL be round-robin: with one valid requester, it wins; with both valid, the one not granted last wins.
REQ-020 On accept, the block SHALL capture data, amt, lr, al and id, and update the round-robin pointer.
REQ-021 On accept with amt=0, the FSM SHALL go to DONE with the operand unchanged; otherwise it SHALL go to SHIFT.
REQ-022 In SHIFT, each cycle SHALL apply step=min(remaining,MAX_STEP) through the shared shifter, register the result, and subtract step from remaining.
REQ-023 When remaining reaches 0 after a pass, the FSM SHALL go to DONE.
REQ-024 Latency from accept to resp_valid SHALL be 1 cycle for amt=0, else ceil(amt/7) SHIFT cycles plus 1.
REQ-025 Amounts of 8 or more SHALL saturate naturally: a logical shift yields 0x00, and an arithmetic right shift yields all copies of the operand's bit 7.
REQ-026 In DONE, resp_valid SHALL be high; resp_data and resp_id SHALL be stable until resp_valid&resp_ready, after which the FSM SHALL enter IDLE.
REQ-027 No new command SHALL be accepted in the same cycle as a response handshake; acceptance resumes in IDLE on the following cycle.
REQ-028 Requester inputs changing while not accepted SHALL have no effect on any state.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL set state=IDLE, resp_valid=0, resp_data=0x00, resp_id=0, busy=0, remaining=0, and the round-robin pointer so that req0 wins the next tie.
REQ-030 rst asserted during SHIFT or DONE SHALL drop the pending job silently; no response is produced for it.
REQ-031 While rst is high, reqN_ready SHALL be low.

Structure
REQ-032 Shared package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and the constants DW=8, AMT_W=5 and MAX_STEP=7.
REQ-033 The shifter SHALL be one combinational sub-module, barrel_shift8 (din[7:0], shamt[2:0], lr, al -> dout[7:0]), instantiated exactly once and shared by both requesters.

Verification
REQ-034 req0 data=0x96, amt=3, lr=1 -> one SHIFT cycle, then resp_data=0xB0, resp_id=0.
REQ-035 req1 data=0x96, amt=10, lr=0, al=1 -> two SHIFT cycles (7 then 3), then resp_data=0xFF, resp_id=1; the same command with al=0 -> resp_data=0x00.
REQ-036 Both requesters valid continuously from reset -> grants in order req0, req1, req0, req1, with resp_id following that order.
REQ-037 req0 data=0x5A, amt=0 -> resp_valid the cycle after accept, resp_data=0x5A.
REQ-038 resp_ready held low for 5 cycles in DONE -> resp_valid, resp_data and resp_id stable and both readies low; a single resp_ready pulse then returns the FSM to IDLE.
REQ-039 rst pulsed during SHIFT of an amt=20 job -> the next cycle shows IDLE, resp_valid=0, busy=0; the dropped job produces no response.
